clks_mon: RTL and testbench

- Checks the divided clocks clk10, clk20 and clk40 produced by the clock generator.
- Samples them with the same fast clock, measures every half-period, and checks the edge-alignment rules between them.
- Raises sticky error flags, and a locked indication once the clock tree is stable.
- Sits beside the generator: feeds the status/debug path and gates datapath start-up until the clocks are stable.

---
 rtl/clks_mon.sv | 182 ++++++++++++++++++
 tb/tb_clks_mon.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clks_mon.sv
// Divided-clock monitor: checks clk10/clk20/clk40 half-periods and edge alignment, reports lock.
// Latency: flags, state and locked update one enabled clk cycle after the offending sample.
// No backpressure: enb low freezes every register, so stalled cycles are not counted.
module clks_mon #(
    parameter int HALF10  = 5,
    parameter int LOCK_HP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       clr,
    input  logic       clk10,
    input  logic       clk20,
    input  logic       clk40,
    output logic       locked,
    output logic       err10,
    output logic       err20,
    output logic       err40,
    output logic       err_ph,
    output logic [1:0] state
);

    // Run counters reach HX+1 at most; 4*HALF10+2 never lands on a power of two,
    // so run+1 also fits without wrapping.
    localparam int CW = $clog2(4*HALF10+2);
    localparam int AW = (LOCK_HP < 2) ? 1 : $clog2(LOCK_HP);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] H10      = CW'(HALF10);
    localparam logic [CW-1:0] H20      = CW'(2*HALF10);
    localparam logic [CW-1:0] H40      = CW'(4*HALF10);
    localparam logic [AW-1:0] ACQ_LAST = AW'(LOCK_HP-1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    state_t          st;
    logic            p10, p20, p40;
    logic [CW-1:0]   run10, run20, run40;
    logic            arm10, arm20, arm40;
    logic [AW-1:0]   acq;

    logic            e10, e20, e40;
    logic            bad10, bad20, bad40, ph_bad;
    logic            err_ev, good40;

    // Next run count: restart on an edge, otherwise count up and park at h+1.
    function automatic logic [CW-1:0] run_next(input logic e, input logic [CW-1:0] r,
                                               input logic [CW-1:0] h);
        logic [CW-1:0] n;
        if (e)
            n = '0;
        else if (r > h)
            n = r;
        else
            n = r + ONE;
        return n;
    endfunction

    // Half-period fault: wrong length on an edge, or a single stuck report when the
    // run first overshoots (the saturated value h+1 never matches again).
    function automatic logic half_bad(input logic arm, input logic e,
                                      input logic [CW-1:0] r, input logic [CW-1:0] h);
        logic b;
        if (!arm)
            b = 1'b0;
        else if (e)
            b = ((r + ONE) != h);
        else
            b = (r == h);
        return b;
    endfunction

    assign e10   = clk10 ^ p10;
    assign e20   = clk20 ^ p20;
    assign e40   = clk40 ^ p40;

    assign bad10 = half_bad(arm10, e10, run10, H10);
    assign bad20 = half_bad(arm20, e20, run20, H20);
    assign bad40 = half_bad(arm40, e40, run40, H40);

    // Each slower clock may only toggle on a rising edge of the next faster one.
    assign ph_bad = arm40 && ((e20 != (!p10 && clk10)) || (e40 != (!p20 && clk20)));

    assign err_ev = bad10 || bad20 || bad40 || ph_bad;
    assign good40 = e40 && arm40 && !err_ev;

    assign state  = st;

    // Sample history, run counters, arm flags and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p10    <= 1'b0;
            p20    <= 1'b0;
            p40    <= 1'b0;
            run10  <= '0;
            run20  <= '0;
            run40  <= '0;
            arm10  <= 1'b0;
            arm20  <= 1'b0;
            arm40  <= 1'b0;
            err10  <= 1'b0;
            err20  <= 1'b0;
            err40  <= 1'b0;
            err_ph <= 1'b0;
        end else if (enb) begin
            p10   <= clk10;
            p20   <= clk20;
            p40   <= clk40;
            run10 <= run_next(e10, run10, H10);
            run20 <= run_next(e20, run20, H20);
            run40 <= run_next(e40, run40, H40);
            if (clr) begin
                arm10  <= 1'b0;
                arm20  <= 1'b0;
                arm40  <= 1'b0;
                err10  <= 1'b0;
                err20  <= 1'b0;
                err40  <= 1'b0;
                err_ph <= 1'b0;
            end else begin
                arm10  <= arm10 | e10;
                arm20  <= arm20 | e20;
                arm40  <= arm40 | e40;
                err10  <= err10 | bad10;
                err20  <= err20 | bad20;
                err40  <= err40 | bad40;
                err_ph <= err_ph | ph_bad;
            end
        end
    end

    // Lock FSM: count clean clk40 half-periods, then watch for any fault.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st     <= ST_IDLE;
            acq    <= '0;
            locked <= 1'b0;
        end else if (enb) begin
            if (clr) begin
                st     <= ST_IDLE;
                acq    <= '0;
                locked <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        acq <= '0;
                        if (e40)
                            st <= ST_ACQ;
                    end
                    ST_ACQ: begin
                        if (err_ev) begin
                            acq <= '0;
                        end else if (good40) begin
                            if (acq == ACQ_LAST) begin
                                st     <= ST_LOCK;
                                locked <= 1'b1;
                                acq    <= '0;
                            end else begin
                                acq <= acq + AW'(1);
                            end
                        end
                    end
                    ST_LOCK: begin
                        if (err_ev) begin
                            st     <= ST_FAIL;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clks_mon.sv
// Directed bench for clks_mon with a behavioural divider feeding the monitor.
// Checks sample 1 time unit after each rising clk edge.
// The divider advances only on enabled edges, mirroring the shared enable.
module tb_clks_mon;

    localparam int HALF10 = 5;

    logic       clk = 1'b0;
    logic       rst, enb, clr;
    logic       g10, g20, g40;
    logic       stall10, inv40;
    int         gcnt;
    wire        clk10 = g10;
    wire        clk20 = g20;
    wire        clk40 = g40 ^ inv40;

    logic       locked, err10, err20, err40, err_ph;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;
    int guard;
    int en_cnt;

    clks_mon #(.HALF10(HALF10), .LOCK_HP(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .enb    (enb),
        .clr    (clr),
        .clk10  (clk10),
        .clk20  (clk20),
        .clk40  (clk40),
        .locked (locked),
        .err10  (err10),
        .err20  (err20),
        .err40  (err40),
        .err_ph (err_ph),
        .state  (state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
        end
    endtask

    // Divider: clk10 toggles every HALF10 enabled cycles, each slower clock on a rising edge.
    task automatic gen_adv();
        if (gcnt == 0 && !stall10) begin
            g10 = ~g10;
            if (g10) begin
                g20 = ~g20;
                if (g20) g40 = ~g40;
            end
        end
        gcnt = (gcnt == HALF10-1) ? 0 : gcnt + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst && enb) gen_adv();
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_err10"},  err10,  0);
        chk({tag, "_err20"},  err20,  0);
        chk({tag, "_err40"},  err40,  0);
        chk({tag, "_err_ph"}, err_ph, 0);
    endtask

    initial begin
        rst = 1'b1; enb = 1'b0; clr = 1'b0;
        g10 = 1'b0; g20 = 1'b0; g40 = 1'b0; gcnt = 0;
        stall10 = 1'b0; inv40 = 1'b0;
        #1 rst = 1'b0;
        step(); step();

        // Reset state
        chk("rst_state",  state,  0);
        chk("rst_locked", locked, 0);
        chk_flags("rst");

        // Healthy divider, continuous enable: edges seen at cycle 1, lock at cycle 81
        rst = 1'b1; enb = 1'b1;
        step();
        chk("A_idle", state, 0);
        step();
        chk("A_acq", state, 1);
        repeat (79) step();
        chk("A_prelock", locked, 0);
        chk("A_prelock_st", state, 1);
        step();
        chk("A_lock", locked, 1);
        chk("A_lock_st", state, 2);
        repeat (920) step();
        chk("A_hold_st", state, 2);
        chk_flags("A_hold");

        // clk10 stuck high: align to a sample where clk10 just rose (also a clk20 edge)
        guard = 0;
        while (!(g10 && gcnt == 2) && guard < 50) begin
            step();
            guard++;
        end
        chk("B_sync_found", guard < 50, 1);
        stall10 = 1'b1;
        repeat (5) step();
        chk("B_err10_pre", err10, 0);
        chk("B_lock_pre",  state, 2);
        step();
        chk("B_err10",  err10,  1);
        chk("B_fail",   state,  3);
        chk("B_locked", locked, 0);
        step(); step();
        stall10 = 1'b0;
        step(); step();
        chk("B_err20_pre", err20, 0);
        step();
        chk("B_err20", err20, 1);

        // clr in FAIL: everything clear next cycle, then relock over 4 clk40 half-periods
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("C_state",  state,  0);
        chk("C_locked", locked, 0);
        chk_flags("C_clr");
        guard = 0;
        while (state != 2'd1 && guard < 100) begin
            step();
            guard++;
        end
        chk("C_acq_seen", state, 1);
        repeat (79) step();
        chk("C_prelock", state, 1);
        step();
        chk("C_lock", locked, 1);

        // Invert clk40 for one sample when run40 is 7
        repeat (7) step();
        chk("D_err40_pre", err40, 0);
        chk("D_lock_pre",  state, 2);
        inv40 = 1'b1;
        step();
        inv40 = 1'b0;
        chk("D_err40",  err40,  1);
        chk("D_err_ph", err_ph, 1);
        chk("D_err10",  err10,  0);
        chk("D_fail",   state,  3);
        chk("D_locked", locked, 0);

        // Async reset in the middle of acquisition
        clr = 1'b1;
        step();
        clr = 1'b0;
        guard = 0;
        while (state != 2'd1 && guard < 100) begin
            step();
            guard++;
        end
        repeat (3) step();
        chk("E_preacq", state, 1);
        #2 rst = 1'b0;
        #1;
        chk("E_rst_state",  state,  0);
        chk("E_rst_locked", locked, 0);
        chk_flags("E_rst");
        g10 = 1'b0; g20 = 1'b0; g40 = 1'b0; gcnt = 0;
        step(); step();
        chk("E_rst_hold", state, 0);
        rst = 1'b1;

        // Random shared enable: lock after the same 81/82 enabled samples
        en_cnt = 0;
        guard  = 0;
        while (en_cnt < 81 && guard < 2000) begin
            enb = 1'($urandom_range(0, 1));
            step();
            if (enb) en_cnt++;
            guard++;
        end
        chk("E_en_count", en_cnt, 81);
        chk("E_prelock",    locked, 0);
        chk("E_prelock_st", state,  1);
        enb = 1'b1;
        step();
        chk("E_lock", locked, 1);
        chk_flags("E_lock");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
